key_irq_ctrl: RTL and testbench
===============================

# key_irq_ctrl

Debounces the raw push-button `key` and turns a debounced press or release into a level interrupt request for the PicoRV32 core's `irq[3]`. It is the upstream feeder of the core's interrupt input: the system top instantiates it and drives `irq[3]` from `irq_out` instead of the raw pad. It also decodes a small register window on the native PicoRV32 memory bus for control, status and interrupt acknowledge, in parallel with the RAM and LED decodes.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_4010: word-aligned base of the 3-word register window.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a level change. Legal range 2..2^20.
- `SYNC_STAGES`, 2: flops in the input synchronizer. Legal range 2..4.

Ports:
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: synchronous, active-high reset.
- `key`  in  1: raw asynchronous button, high = pressed.
- `mem_valid`  in  1: PicoRV32 native bus request.
- `mem_addr`  in  32: byte address.
- `mem_wdata`  in  32: write data.
- `mem_wstrb`  in  4: byte strobes; 0 = read.
- `mem_ready`  out  1: one-cycle acknowledge, asserted for window hits only.
- `mem_rdata`  out  32: read data, valid while `mem_ready`=1, else 0.
- `eoi_in`  in  1: core `eoi[3]`; a rising edge clears the pending bit.
- `irq_out`  out  1: level interrupt request to core `irq[3]`.

## Operation
- Synchronizer: `key` passes through `SYNC_STAGES` flops, producing `key_s`.
- Debounce FSM states:
  - IDLE_LOW: if `key_s`=1, go to WAIT_HIGH with cnt=0.
  - WAIT_HIGH: if `key_s`=0, return to IDLE_LOW. If cnt=`DEBOUNCE_CYCLES`-1, go to IDLE_HIGH and emit a one-cycle `rise` pulse. Otherwise cnt++.
  - IDLE_HIGH and WAIT_LOW mirror the above and emit a one-cycle `fall` pulse.
  - `key_db`=1 in IDLE_HIGH and WAIT_LOW.
- Counter width is clog2(`DEBOUNCE_CYCLES`). Any bounce restarts qualification from zero.
- Registers (word offsets):
  - +0 STATUS, RO: [0] `key_db`, [1] pending, [15:8] press_cnt, other bits 0.
  - +4 CTRL, RW: [0] irq_en, [1] edge_sel (0 = interrupt on `rise`, 1 = on `fall`), other bits 0. Writes honour `mem_wstrb[0]` only.
  - +8 CLEAR, WO, reads as 0: writing 1 to [0] with `mem_wstrb[0]` clears pending.
  - Writes to STATUS are ignored but still acknowledged.
- press_cnt: 8-bit count of `rise` pulses regardless of irq_en. Wraps 255 to 0.
- pending:
  - Set on the selected edge pulse while irq_en=1.
  - Cleared by a CLEAR write or by an `eoi_in` rising edge.
  - If set and clear occur in the same cycle, set wins.
  - Edges while irq_en=0 are dropped, not latched.
- `irq_out` = pending & irq_en. Clearing irq_en masks the request but keeps pending.
- Bus decode: hit = `mem_valid` & !`mem_ready` & `mem_addr`[31:4]==`BASE_ADDR`[31:4] & `mem_addr`[3:2]!=3. Offset +12 is not decoded and gets no ready.

## Timing
- Reset values: `irq_out`=0, `mem_ready`=0, `mem_rdata`=0, CTRL=0, pending=0, press_cnt=0, FSM=IDLE_LOW, synchronizer flops=0.
- Key edge to `rise`/`fall` pulse: `SYNC_STAGES`+`DEBOUNCE_CYCLES` cycles.
- Edge pulse to `irq_out`: 1 cycle (registered).
- Bus access:
  - A hit in cycle N gives `mem_ready`=1 and `mem_rdata` in cycle N+1, for exactly one cycle.
  - The register write takes effect at the N+1 edge.
  - Back-to-back accesses need a fresh `mem_valid` evaluation; at most one ack every 2 cycles.
- Reset mid-qualification returns the FSM to IDLE_LOW. If the key is still held after reset, it is re-qualified and produces a `rise`.
- CLEAR write and `eoi_in` rising edge in the same cycle: single clear, no error.

## Structure
- Shared package `key_irq_pkg` holds:
  - Register offset constants (`KIRQ_STATUS`=0, `KIRQ_CTRL`=1, `KIRQ_CLEAR`=2).
  - Field bit positions.
  - The 2-bit debounce state encoding (IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW).
- One sub-module, `key_debounce`: synchronizer, FSM and counter; outputs `key_db`, `rise`, `fall`.
- The top level `key_irq_ctrl` holds the registers, bus decode and interrupt logic.

## Test plan
- Clean press with `DEBOUNCE_CYCLES`=8 and CTRL=1: key goes 0 to 1 and is held → `irq_out`=1 exactly 11 cycles after the key edge; STATUS reads 0x0000_0103.
- Bounce: key toggles every 5 cycles for 40 cycles, then settles to 0 → no `rise`, press_cnt=0, `irq_out` stays 0.
- Acknowledge: with pending=1, write 1 to CLEAR → `irq_out`=0 the cycle after `mem_ready`. Repeat via an `eoi_in` pulse → same result.
- Simultaneous events: a `rise` and a CLEAR write commit in the same cycle → pending remains 1.
- Masking and wrap:
  - CTRL=0, 256 qualified presses → press_cnt=0x00 and `irq_out` never asserts.
  - CTRL=3 → only a release raises `irq_out`.
- Decode: read at `BASE_ADDR`+12 → no `mem_ready`. Assert `reset` mid-WAIT_HIGH with key held → FSM restarts and `rise` occurs `DEBOUNCE_CYCLES`+2 cycles after `reset` drops.

Source files
------------

// File: rtl/key_irq_pkg.sv
// key_irq_pkg: register offsets, field positions and debounce state encoding for key_irq_ctrl.
package key_irq_pkg;
  localparam logic [1:0] KIRQ_STATUS = 2'd0;
  localparam logic [1:0] KIRQ_CTRL = 2'd1;
  localparam logic [1:0] KIRQ_CLEAR = 2'd2;
  localparam int ST_KEY_DB = 0;
  localparam int ST_PENDING = 1;
  localparam int ST_CNT_LSB = 8;
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_EDGE_SEL = 1;
  localparam int CLEAR_BIT = 0;
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} db_state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes the raw key and qualifies level changes over DEBOUNCE_CYCLES stable cycles.
module key_debounce
  import key_irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt, cnt_next;
  logic key_s, done;
  db_state_t state, state_next;
  assign key_s = sync[SYNC_STAGES-1];
  assign done = cnt == CNT_MAX;
  assign key_db = state == IDLE_HIGH || state == WAIT_LOW;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      state <= IDLE_LOW;
      cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], key};
      state <= state_next;
      cnt <= cnt_next;
    end
  end
  // rise/fall are decoded from the qualifying state so the interrupt registers one cycle later
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    rise = 1'b0;
    fall = 1'b0;
    case (state)
      IDLE_LOW: if (key_s) begin
        state_next = WAIT_HIGH;
        cnt_next = '0;
      end
      WAIT_HIGH: if (!key_s) state_next = IDLE_LOW;
        else if (done) begin
          state_next = IDLE_HIGH;
          rise = 1'b1;
        end else cnt_next = cnt + CW'(1);
      IDLE_HIGH: if (!key_s) begin
        state_next = WAIT_LOW;
        cnt_next = '0;
      end
      WAIT_LOW: if (key_s) state_next = IDLE_HIGH;
        else if (done) begin
          state_next = IDLE_LOW;
          fall = 1'b1;
        end else cnt_next = cnt + CW'(1);
    endcase
  end
endmodule

// File: rtl/key_irq_ctrl.sv
// key_irq_ctrl: debounced key interrupt source with a 3-word register window on the PicoRV32 native bus.
module key_irq_ctrl
  import key_irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_4010,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        eoi_in,
  output logic        irq_out
);
  logic key_db, rise, fall, irq_en, edge_sel, pending, eoi_q, hit, wr, set, clr;
  logic [7:0] press_cnt;
  logic [1:0] idx;
  logic [31:0] rd;
  logic unused_bits;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_db (
    .clk(clk), .reset(reset), .key(key), .key_db(key_db), .rise(rise), .fall(fall)
  );
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:2], mem_wstrb[3:1]};
  assign idx = mem_addr[3:2];
  // !mem_ready forces a fresh request evaluation between acks
  assign hit = mem_valid && !mem_ready && mem_addr[31:4] == BASE_ADDR[31:4] && idx != 2'd3;
  assign wr = hit && mem_wstrb[0];
  assign set = irq_en && (edge_sel ? fall : rise);
  assign clr = (wr && idx == KIRQ_CLEAR && mem_wdata[CLEAR_BIT]) || (eoi_in && !eoi_q);
  assign irq_out = pending && irq_en;
  always_comb begin
    rd = '0;
    if (idx == KIRQ_STATUS) begin
      rd[ST_KEY_DB] = key_db;
      rd[ST_PENDING] = pending;
      rd[ST_CNT_LSB+:8] = press_cnt;
    end
    if (idx == KIRQ_CTRL) begin
      rd[CTRL_IRQ_EN] = irq_en;
      rd[CTRL_EDGE_SEL] = edge_sel;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      eoi_q <= 1'b0;
      pending <= 1'b0;
      press_cnt <= '0;
      irq_en <= 1'b0;
      edge_sel <= 1'b0;
    end else begin
      mem_ready <= hit;
      mem_rdata <= hit ? rd : '0;
      eoi_q <= eoi_in;
      pending <= set || (pending && !clr);
      if (rise) press_cnt <= press_cnt + 8'd1;
      if (wr && idx == KIRQ_CTRL) begin
        irq_en <= mem_wdata[CTRL_IRQ_EN];
        edge_sel <= mem_wdata[CTRL_EDGE_SEL];
      end
    end
  end
endmodule

// File: tb/tb_key_irq_ctrl.sv
// tb_key_irq_ctrl: randomized and directed stimulus scored against a behavioural model of the key interrupt block.
module tb_key_irq_ctrl;
  localparam int DEB = 8;
  localparam int SYNC = 2;
  localparam logic [31:0] BASE = 32'h0000_4010;
  logic clk = 0, reset, key, mem_valid, eoi_in;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic mem_ready, irq_out;
  int vectors = 0, miscompares = 0;
  logic [31:0] exp_q[$];
  logic [SYNC-1:0] kp;
  int db_m, run_m, en_m, sel_m, pend_m, cnt_m, eoiq_m, rdy_m, off_m;
  logic started = 0, hit_m, wr_m, ks, ev_r, ev_f, clr_m;
  logic [31:0] e;
  key_irq_ctrl #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .key(key), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .eoi_in(eoi_in), .irq_out(irq_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask
  // Reference model: a level is accepted once the synchronized key has differed from it for DEB+1 samples in a row
  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      kp = '0; db_m = 0; run_m = 0; en_m = 0; sel_m = 0; pend_m = 0; cnt_m = 0; eoiq_m = 0; rdy_m = 0;
    end else begin
      off_m = int'(mem_addr[3:2]);
      hit_m = mem_valid && rdy_m == 0 && (mem_addr >> 4) == (BASE >> 4) && off_m != 3;
      wr_m = hit_m && mem_wstrb[0];
      if (hit_m) exp_q.push_back(off_m == 0 ? 32'(db_m + 2 * pend_m + 256 * cnt_m) : off_m == 1 ? 32'(en_m + 2 * sel_m) : 32'd0);
      ks = kp[SYNC-1];
      kp = {kp[SYNC-2:0], key};
      ev_r = 0;
      ev_f = 0;
      if (int'(ks) != db_m) begin
        run_m++;
        if (run_m == DEB + 1) begin
          db_m = int'(ks); ev_r = ks; ev_f = !ks; run_m = 0;
        end
      end else run_m = 0;
      clr_m = (wr_m && off_m == 2 && mem_wdata[0]) || (eoi_in && eoiq_m == 0);
      if (en_m != 0 && (sel_m != 0 ? ev_f : ev_r)) pend_m = 1;
      else if (clr_m) pend_m = 0;
      if (ev_r) cnt_m = (cnt_m + 1) % 256;
      if (wr_m && off_m == 1) begin
        en_m = int'(mem_wdata[0]); sel_m = int'(mem_wdata[1]);
      end
      eoiq_m = int'(eoi_in);
      rdy_m = int'(hit_m);
    end
  end
  always @(negedge clk) if (started) begin
    chk("irq_out", {31'd0, irq_out}, {31'd0, pend_m != 0 && en_m != 0});
    if (mem_ready) begin
      if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rdata", mem_rdata, e);
      end
    end else chk("idle_rdata", mem_rdata, 32'd0);
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    @(negedge clk);
    mem_valid = 0; mem_wstrb = 0;
    @(negedge clk);
  endtask
  task automatic rd(input int off);
    bus(BASE + 32'(off * 4), $urandom, 4'd0);
  endtask
  task automatic wr(input int off, input logic [31:0] d);
    bus(BASE + 32'(off * 4), d, {3'($urandom), 1'b1});
  endtask
  task automatic press();
    key = 1; cyc(14); key = 0; cyc(14);
  endtask
  initial begin
    reset = 1; key = 0; mem_valid = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0; eoi_in = 0;
    cyc(3);
    reset = 0;
    rd(0); rd(1); rd(2);
    wr(1, 1);
    key = 1; cyc(15);
    rd(0);
    wr(2, 1); cyc(2);
    key = 0; cyc(15);
    key = 1; cyc(15);
    eoi_in = 1; cyc(1); eoi_in = 0; cyc(2);
    key = 0; cyc(15);
    for (int i = 0; i < 8; i++) begin
      key = ~key; cyc(5);
    end
    key = 0; cyc(15);
    rd(0);
    key = 1; cyc(10);
    wr(2, 1); cyc(3);
    rd(0);
    key = 0; cyc(15);
    wr(2, 1);
    wr(1, 0);
    for (int i = 0; i < 256; i++) press();
    rd(0);
    wr(1, 3);
    key = 1; cyc(15);
    key = 0; cyc(15);
    wr(1, 2); cyc(2);
    wr(1, 3); cyc(2);
    eoi_in = 1; wr(2, 1); eoi_in = 0; cyc(2);
    bus(BASE + 12, 0, 0);
    bus(BASE + 16, 0, 0);
    wr(0, 32'hffff_ffff);
    mem_valid = 1; mem_addr = BASE; mem_wstrb = 0; cyc(4); mem_valid = 0; cyc(2);
    key = 1; cyc(5);
    reset = 1; cyc(2); reset = 0;
    wr(1, 1); cyc(15);
    rd(0);
    key = 0; cyc(15);
    repeat (300) begin
      case ($urandom_range(0, 5))
        0: begin key = ~key; cyc($urandom_range(1, 14)); end
        1: rd($urandom_range(0, 3));
        2: bus(BASE + 4, $urandom, 4'($urandom));
        3: wr(2, $urandom);
        4: begin eoi_in = 1; cyc($urandom_range(1, 2)); eoi_in = 0; cyc(1); end
        default: cyc($urandom_range(1, 20));
      endcase
    end
    cyc(5);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("missing_ready", 32'hxxxx_xxxx, e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
